// File: rtl/imsic_access_arbiter_if.sv
// Requester-side and IMSIC-side channels of the IMSIC CSR access arbiter.
// The slave modport is the arbiter. The master modport is the surrounding requesters and IMSICs.
interface imsic_access_arbiter_if #(
  parameter int NR_REQ                = 4,
  parameter int NR_IMSICS             = 4,
  parameter int NR_VS_FILES_PER_IMSIC = 1,
  parameter int VS_INTP_FILE_LEN      = $clog2(NR_VS_FILES_PER_IMSIC),
  parameter int IDX_W                 = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1
);
  logic [NR_REQ-1:0]                        i_req_valid;
  logic [NR_REQ-1:0]                        o_req_ready;
  logic [NR_REQ-1:0][IDX_W-1:0]             i_req_imsic;
  logic [NR_REQ-1:0][1:0]                   i_req_priv_lvl;
  logic [NR_REQ-1:0][VS_INTP_FILE_LEN:0]    i_req_vgein;
  logic [NR_REQ-1:0][31:0]                  i_req_addr;
  logic [NR_REQ-1:0][31:0]                  i_req_data;
  logic [NR_REQ-1:0]                        i_req_we;
  logic [NR_REQ-1:0]                        i_req_claim;
  logic [NR_REQ-1:0]                        i_req_lock;
  logic [NR_REQ-1:0]                        o_rsp_valid;
  logic [31:0]                              o_rsp_data;
  logic                                     o_rsp_exception;
  logic [NR_IMSICS-1:0][1:0]                o_priv_lvl;
  logic [NR_IMSICS-1:0][VS_INTP_FILE_LEN:0] o_vgein;
  logic [NR_IMSICS-1:0][31:0]               o_imsic_addr;
  logic [NR_IMSICS-1:0][31:0]               o_imsic_data;
  logic [NR_IMSICS-1:0]                     o_imsic_we;
  logic [NR_IMSICS-1:0]                     o_imsic_claim;
  logic [NR_IMSICS-1:0][31:0]               i_imsic_data;
  logic [NR_IMSICS-1:0]                     i_imsic_exception;

  modport slave (
    input  i_req_valid, i_req_imsic, i_req_priv_lvl, i_req_vgein, i_req_addr,
           i_req_data, i_req_we, i_req_claim, i_req_lock, i_imsic_data, i_imsic_exception,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_exception, o_priv_lvl, o_vgein,
           o_imsic_addr, o_imsic_data, o_imsic_we, o_imsic_claim
  );

  modport master (
    output i_req_valid, i_req_imsic, i_req_priv_lvl, i_req_vgein, i_req_addr,
           i_req_data, i_req_we, i_req_claim, i_req_lock, i_imsic_data, i_imsic_exception,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_exception, o_priv_lvl, o_vgein,
           o_imsic_addr, o_imsic_data, o_imsic_we, o_imsic_claim
  );
endinterface

// File: rtl/imsic_access_arbiter.sv
// Round-robin arbiter for per-IMSIC CSR channels: accept at T, bus pulse at T+1, response at T+2; ready only when IDLE.
// Optional grant lock for read-modify-write sequences is enabled by defining IMSIC_ARB_LOCK_EN.
module imsic_access_arbiter #(
  parameter int NR_REQ                = 4,
  parameter int NR_IMSICS             = 4,
  parameter int NR_VS_FILES_PER_IMSIC = 1,
  parameter int VS_INTP_FILE_LEN      = $clog2(NR_VS_FILES_PER_IMSIC),
  parameter int IDX_W                 = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1
) (
  input logic                   i_clk,
  input logic                   i_rst,
  imsic_access_arbiter_if.slave bus
);
  localparam int REQ_W = $clog2(NR_REQ);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  logic [REQ_W-1:0]  last_grant;
  logic [REQ_W-1:0]  gnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NR_REQ-1:0] cand;
  logic              gnt_found;
  logic [REQ_W-1:0]  gnt_idx;
  logic [REQ_W-1:0]  rr_idx;
  int                rr_j;
  logic [31:0]       sel_data;
  logic              sel_exc;

`ifdef IMSIC_ARB_LOCK_EN
  logic             lock_act;
  logic [REQ_W-1:0] lock_own;
  logic             lock_hold;

  // A held lock narrows arbitration to its owner for as long as the owner keeps requesting.
  assign lock_hold = lock_act && bus.i_req_valid[lock_own];
  assign cand      = lock_hold ? (bus.i_req_valid & (NR_REQ'(1) << lock_own)) : bus.i_req_valid;
`else
  logic unused_lock;
  assign unused_lock = ^bus.i_req_lock;
  assign cand        = bus.i_req_valid;
`endif

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    rr_j      = 0;
    rr_idx    = '0;
    for (int k = 1; k <= NR_REQ; k++) begin
      rr_j = int'(last_grant) + k;
      if (rr_j >= NR_REQ) rr_j = rr_j - NR_REQ;
      rr_idx = REQ_W'(rr_j);
      if (!gnt_found && cand[rr_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = rr_idx;
      end
    end
  end

  assign bus.o_req_ready = (state == IDLE && gnt_found && !i_rst) ? (NR_REQ'(1) << gnt_idx) : '0;

  // An index with no matching IMSIC falls through to data 0 / exception 1.
  always_comb begin
    sel_data = '0;
    sel_exc  = 1'b1;
    for (int i = 0; i < NR_IMSICS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_data = bus.i_imsic_data[i];
        sel_exc  = bus.i_imsic_exception[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state               <= IDLE;
      last_grant          <= REQ_W'(NR_REQ - 1);
      gnt_q               <= '0;
      idx_q               <= '0;
      bus.o_rsp_valid     <= '0;
      bus.o_rsp_data      <= '0;
      bus.o_rsp_exception <= 1'b0;
      bus.o_priv_lvl      <= '0;
      bus.o_vgein         <= '0;
      bus.o_imsic_addr    <= '0;
      bus.o_imsic_data    <= '0;
      bus.o_imsic_we      <= '0;
      bus.o_imsic_claim   <= '0;
`ifdef IMSIC_ARB_LOCK_EN
      lock_act            <= 1'b0;
      lock_own            <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef IMSIC_ARB_LOCK_EN
          if (lock_act && !bus.i_req_valid[lock_own]) lock_act <= 1'b0;
`endif
          if (gnt_found) begin
            gnt_q <= gnt_idx;
            idx_q <= bus.i_req_imsic[gnt_idx];
            for (int i = 0; i < NR_IMSICS; i++) begin
              if (bus.i_req_imsic[gnt_idx] == IDX_W'(i)) begin
                bus.o_priv_lvl[i]    <= bus.i_req_priv_lvl[gnt_idx];
                bus.o_vgein[i]       <= bus.i_req_vgein[gnt_idx];
                bus.o_imsic_addr[i]  <= bus.i_req_addr[gnt_idx];
                bus.o_imsic_data[i]  <= bus.i_req_data[gnt_idx];
                bus.o_imsic_we[i]    <= bus.i_req_we[gnt_idx];
                bus.o_imsic_claim[i] <= bus.i_req_claim[gnt_idx];
              end
            end
`ifdef IMSIC_ARB_LOCK_EN
            lock_act <= bus.i_req_lock[gnt_idx];
            lock_own <= gnt_idx;
`endif
            state <= ISSUE;
          end
        end
        ISSUE: begin
          bus.o_priv_lvl      <= '0;
          bus.o_vgein         <= '0;
          bus.o_imsic_addr    <= '0;
          bus.o_imsic_data    <= '0;
          bus.o_imsic_we      <= '0;
          bus.o_imsic_claim   <= '0;
          bus.o_rsp_data      <= sel_data;
          bus.o_rsp_exception <= sel_exc;
          bus.o_rsp_valid     <= NR_REQ'(1) << gnt_q;
          last_grant          <= gnt_q;
          state               <= RESP;
        end
        RESP: begin
          bus.o_rsp_valid <= '0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imsic_access_arbiter.sv
// Bench for imsic_access_arbiter: directed vector table, multi-cycle sequences, and random traffic against a transaction-level model.
module tb_imsic_access_arbiter;
  localparam int NR_REQ    = 4;
  localparam int NR_IMSICS = 3;
  localparam int NR_VS     = 1;
  localparam int VSL       = $clog2(NR_VS);
  localparam int IDX_W     = 2;
  localparam int VG_W      = VSL + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [1:0]       priv;
    logic [VG_W-1:0]  vg;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic             we;
    logic             claim;
    logic             lock;
  } txn_t;

  typedef struct {
    int          req;
    txn_t        t;
    logic [31:0] exp_d;
    logic        exp_e;
    bit          on_bus;
  } vec_t;

  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  imsic_access_arbiter_if #(.NR_REQ(NR_REQ), .NR_IMSICS(NR_IMSICS), .NR_VS_FILES_PER_IMSIC(NR_VS),
                            .VS_INTP_FILE_LEN(VSL), .IDX_W(IDX_W)) bus();

  imsic_access_arbiter #(.NR_REQ(NR_REQ), .NR_IMSICS(NR_IMSICS), .NR_VS_FILES_PER_IMSIC(NR_VS),
                         .VS_INTP_FILE_LEN(VSL), .IDX_W(IDX_W)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  // IMSIC stand-in: address 0x70 reads 5, otherwise {index+1, addr[23:0]}; addr[8] raises an exception.
  function automatic logic [31:0] imsic_rd(int i, logic [31:0] a);
    return (a == 32'h70) ? 32'h5 : {8'(i + 1), a[23:0]};
  endfunction

  always_comb begin
    for (int i = 0; i < NR_IMSICS; i++) begin
      bus.i_imsic_data[i]      = imsic_rd(i, bus.o_imsic_addr[i]);
      bus.i_imsic_exception[i] = bus.o_imsic_addr[i][8];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;
  txn_t rq [NR_REQ];
  logic [NR_REQ-1:0] rv;

  task automatic chk(string nm, logic [127:0] got, logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic txn_t mk(int idx, int priv, int vg, logic [31:0] addr, logic [31:0] data,
                              bit we, bit claim, bit lock);
    txn_t t;
    t.idx = IDX_W'(idx); t.priv = 2'(priv); t.vg = VG_W'(vg);
    t.addr = addr; t.data = data; t.we = we; t.claim = claim; t.lock = lock;
    return t;
  endfunction

  function automatic logic [NR_REQ-1:0] oh(int r);
    logic [NR_REQ-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] exp_data(txn_t t);
    return (int'(t.idx) < NR_IMSICS) ? imsic_rd(int'(t.idx), t.addr) : 32'h0;
  endfunction

  function automatic logic exp_exc(txn_t t);
    return (int'(t.idx) < NR_IMSICS) ? t.addr[8] : 1'b1;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive();
    bus.i_req_valid = rv;
    for (int r = 0; r < NR_REQ; r++) begin
      bus.i_req_imsic[r]    = rq[r].idx;
      bus.i_req_priv_lvl[r] = rq[r].priv;
      bus.i_req_vgein[r]    = rq[r].vg;
      bus.i_req_addr[r]     = rq[r].addr;
      bus.i_req_data[r]     = rq[r].data;
      bus.i_req_we[r]       = rq[r].we;
      bus.i_req_claim[r]    = rq[r].claim;
      bus.i_req_lock[r]     = rq[r].lock;
    end
  endtask

  // Only the targeted IMSIC bus carries the fields; every other bus is zero.
  task automatic chk_bus(string nm, bit on, txn_t t);
    logic [NR_IMSICS-1:0][31:0]     ea, ed;
    logic [NR_IMSICS-1:0][1:0]      ep;
    logic [NR_IMSICS-1:0][VG_W-1:0] ev;
    logic [NR_IMSICS-1:0]           ew, ec;
    ea = '0; ed = '0; ep = '0; ev = '0; ew = '0; ec = '0;
    for (int i = 0; i < NR_IMSICS; i++) begin
      if (on && int'(t.idx) == i) begin
        ea[i] = t.addr; ed[i] = t.data; ep[i] = t.priv; ev[i] = t.vg; ew[i] = t.we; ec[i] = t.claim;
      end
    end
    chk({nm, "_addr"},  bus.o_imsic_addr,  ea);
    chk({nm, "_data"},  bus.o_imsic_data,  ed);
    chk({nm, "_priv"},  bus.o_priv_lvl,    ep);
    chk({nm, "_vgein"}, bus.o_vgein,       ev);
    chk({nm, "_we"},    bus.o_imsic_we,    ew);
    chk({nm, "_claim"}, bus.o_imsic_claim, ec);
  endtask

  task automatic chk_all_zero(string nm);
    chk({nm, "_ready"},    bus.o_req_ready,     '0);
    chk({nm, "_rsp_vld"},  bus.o_rsp_valid,     '0);
    chk({nm, "_rsp_data"}, bus.o_rsp_data,      '0);
    chk({nm, "_rsp_exc"},  bus.o_rsp_exception, '0);
    chk_bus(nm, 1'b0, '0);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    rv    = '0;
    drive();
    tick();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic run_random(int ncyc);
    logic [NR_REQ-1:0] prev_rdy, elig, exp_rdy;
    int   m_last, w;
    bit   iss_v, rsp_v, lk_act;
    int   iss_req, rsp_req, lk_own;
    txn_t iss_t, rsp_t;
    prev_rdy = '0; m_last = NR_REQ - 1;
    iss_v = 0; rsp_v = 0; lk_act = 0; iss_req = 0; rsp_req = 0; lk_own = 0;
    iss_t = '0; rsp_t = '0;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      for (int r = 0; r < NR_REQ; r++) begin
        if (rv[r] && prev_rdy[r]) rv[r] = 1'b0;
        if (!rv[r] && $urandom_range(0, 2) == 0) begin
          rv[r] = 1'b1;
          rq[r] = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
                     ($urandom_range(0, 7) == 0) ? 32'h70 : ($urandom & 32'h3FF),
                     $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0);
        end
      end
      drive();
      #1;
      // The arbiter is occupied for the two cycles following each accept.
      w = -1;
      exp_rdy = '0;
      if (!iss_v && !rsp_v) begin
        elig = rv;
`ifdef IMSIC_ARB_LOCK_EN
        if (lk_act && rv[lk_own]) elig = oh(lk_own);
        else lk_act = 0;
`endif
        for (int k = 1; k <= NR_REQ; k++) begin
          if (w < 0 && elig[(m_last + k) % NR_REQ]) w = (m_last + k) % NR_REQ;
        end
        if (w >= 0) exp_rdy = oh(w);
      end
      chk("rnd_ready", bus.o_req_ready, exp_rdy);
      chk_bus("rnd_bus", iss_v, iss_t);
      chk("rnd_rsp_vld", bus.o_rsp_valid, rsp_v ? oh(rsp_req) : '0);
      if (rsp_v) begin
        chk("rnd_rsp_data", bus.o_rsp_data, exp_data(rsp_t));
        chk("rnd_rsp_exc", bus.o_rsp_exception, exp_exc(rsp_t));
      end
      rsp_v = iss_v; rsp_t = iss_t; rsp_req = iss_req;
      iss_v = (w >= 0);
      if (w >= 0) begin
        iss_t = rq[w]; iss_req = w; m_last = w;
        lk_act = rq[w].lock; lk_own = w;
      end
      prev_rdy = bus.o_req_ready;
    end
    tick();
    rv = '0;
    drive();
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [6];
    txn_t ts [NR_REQ];
    vt[0] = '{1, mk(2, 3, 0, 32'h70,  32'h0,    0, 0, 0), 32'h0000_0005, 1'b0, 1'b1};
    vt[1] = '{2, mk(1, 1, 1, 32'h40,  32'hA5,   1, 1, 0), 32'h0200_0040, 1'b0, 1'b1};
    vt[2] = '{0, mk(0, 0, 0, 32'h130, 32'h0,    0, 0, 0), 32'h0100_0130, 1'b1, 1'b1};
    vt[3] = '{3, mk(3, 2, 0, 32'h70,  32'hFFFF, 1, 0, 0), 32'h0000_0000, 1'b1, 1'b0};
    vt[4] = '{3, mk(2, 1, 1, 32'hFF0, 32'h1234, 1, 0, 0), 32'h0300_0FF0, 1'b1, 1'b1};
    vt[5] = '{0, mk(1, 2, 0, 32'h71,  32'h0,    0, 1, 0), 32'h0200_0071, 1'b0, 1'b1};
    for (int r = 0; r < NR_REQ; r++) rq[r] = '0;

    do_reset();
    #1;
    chk_all_zero("reset");

    for (int v = 0; v < 6; v++) begin
      tick();
      rv = oh(vt[v].req);
      rq[vt[v].req] = vt[v].t;
      drive();
      #1;
      chk("vec_ready", bus.o_req_ready, oh(vt[v].req));
      chk("vec_idle_bus_quiet", bus.o_imsic_addr, '0);
      tick();
      rv = '0;
      drive();
      #1;
      chk_bus("vec_issue", vt[v].on_bus, vt[v].t);
      chk("vec_issue_rsp_vld", bus.o_rsp_valid, '0);
      chk("vec_issue_ready", bus.o_req_ready, '0);
      tick();
      chk("vec_rsp_vld", bus.o_rsp_valid, oh(vt[v].req));
      chk("vec_rsp_data", bus.o_rsp_data, vt[v].exp_d);
      chk("vec_rsp_exc", bus.o_rsp_exception, vt[v].exp_e);
      chk_bus("vec_rsp_bus", 1'b0, '0);
    end
    tick();
    chk("hold_rsp_vld", bus.o_rsp_valid, '0);
    chk("hold_rsp_data", bus.o_rsp_data, 32'h0200_0071);

    // All requesters held valid from reset: grants 0,1,2,3,0 three cycles apart.
    do_reset();
    for (int r = 0; r < NR_REQ; r++) begin
      ts[r] = mk(r % NR_IMSICS, r, 0, 32'h10 * (r + 1), 32'(r), 1, 0, 0);
      rq[r] = ts[r];
    end
    for (int c = 0; c < 15; c++) begin
      tick();
      rv = '1;
      drive();
      #1;
      chk("simul_ready", bus.o_req_ready, (c % 3 == 0) ? oh((c / 3) % NR_REQ) : '0);
      chk("simul_we_count", $countones(bus.o_imsic_we), (c % 3 == 1) ? 1 : 0);
      chk("simul_rsp_vld", bus.o_rsp_valid, (c % 3 == 2) ? oh((c / 3) % NR_REQ) : '0);
      if (c % 3 == 1) chk_bus("simul_bus", 1'b1, ts[(c / 3) % NR_REQ]);
    end
    tick();
    rv = '0;
    drive();
    tick();
    tick();

    // Reset during ISSUE drops the response and restores requester-0 priority.
    do_reset();
    tick();
    rv = 4'b0001;
    rq[0] = mk(0, 1, 0, 32'h20, 32'h1, 1, 0, 0);
    drive();
    #1;
    chk("rst_first_ready", bus.o_req_ready, 4'b0001);
    tick();
    rv = '0;
    drive();
    tick();
    tick();
    rv = 4'b0100;
    rq[2] = mk(1, 2, 1, 32'h50, 32'h9, 1, 1, 0);
    drive();
    #1;
    chk("rst_second_ready", bus.o_req_ready, 4'b0100);
    tick();
    rv = '0;
    i_rst = 1'b1;
    drive();
    tick();
    chk_all_zero("rst_after");
    i_rst = 1'b0;
    tick();
    chk_all_zero("rst_quiet");
    tick();
    rv = 4'b1001;
    rq[3] = mk(2, 0, 0, 32'h60, 32'h3, 0, 0, 0);
    drive();
    #1;
    chk("rst_prio_ready", bus.o_req_ready, 4'b0001);
    tick();
    rv = '0;
    drive();
    tick();
    tick();

    // Lock: req1 locks, then both req0 and req1 request.
    do_reset();
    tick();
    rv = 4'b0010;
    rq[1] = mk(0, 3, 0, 32'h40, 32'h0, 0, 0, 1);
    drive();
    #1;
    chk("lock_first_ready", bus.o_req_ready, 4'b0010);
    tick();
    rv = 4'b0011;
    rq[1] = mk(0, 3, 0, 32'h41, 32'h7, 1, 0, 0);
    rq[0] = mk(2, 1, 0, 32'h42, 32'h8, 1, 0, 0);
    drive();
    tick();
    tick();
`ifdef IMSIC_ARB_LOCK_EN
    chk("lock_second_ready", bus.o_req_ready, 4'b0010);
    tick();
    rv[1] = 1'b0;
`else
    chk("lock_second_ready", bus.o_req_ready, 4'b0001);
    tick();
    rv[0] = 1'b0;
`endif
    drive();
    tick();
    tick();
`ifdef IMSIC_ARB_LOCK_EN
    chk("lock_third_ready", bus.o_req_ready, 4'b0001);
`else
    chk("lock_third_ready", bus.o_req_ready, 4'b0010);
`endif
    tick();
    rv = '0;
    drive();
    tick();
    tick();

    do_reset();
    run_random(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
